uart_core_cfg: RTL
==================

Name: uart_core_cfg

Overview:
Parametrised, runtime-configurable full-duplex UART. It is the next generation of the fixed-format uart_rx_tx and replaces the 2-bit freq_control preset with a programmable baud divisor. Adds a configurable data width, optional parity, 1/2 stop bits, oversampled RX with false-start rejection, and parity/framing error flags. It sits between the on-chip command logic and the chip UART pins.

Parameters:
CLOCK_FREQ, 10000000, system clock in Hz; documentation and bench timing only.
DATA_BITS, 8, payload width; legal range 5..9.
OVERSAMPLE, 16, ticks per bit; even number, at least 8.
DIV_W, 16, width of the baud divisor.

Ports:
clk_int  in  1  system clock; all logic runs on the rising edge.
uart_reset  in  1  synchronous reset, active-high.
baud_div  in  DIV_W  oversample tick period minus 1; one tick every baud_div+1 clocks.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
stop_bits  in  1  0 selects 1 stop bit, 1 selects 2 stop bits.
uart_transmit_data  in  DATA_BITS  TX payload.
uart_tx_start  in  1  TX request.
uart_tx_ready  out  1  TX idle; a request is accepted only while this is high.
uart_tx_d_out  out  1  serial TX line; idles high.
uart_rx_d_in  in  1  serial RX line; asynchronous.
uart_received_data  out  DATA_BITS  last received payload.
uart_rx_valid  out  1  one-cycle strobe marking a new received word.
uart_rx_parity_err  out  1  parity result of the last word; valid together with uart_rx_valid.
uart_rx_frame_err  out  1  first stop bit sampled low; valid together with uart_rx_valid.

Behaviour:
- Reset values: uart_tx_d_out=1, uart_tx_ready=1, uart_rx_valid=0, both error flags 0, uart_received_data=0, all counters 0, both FSMs IDLE.
- Reset asserted mid-frame aborts immediately. uart_tx_d_out is high on the cycle after reset is sampled, and no partial word is reported.
- Tick generator:
  - Free-running counter 0..baud_div. tick=1 for one clock when counter==baud_div, then counter returns to 0.
  - baud_div=0 gives a tick every clock.
  - One bit time = OVERSAMPLE ticks.
- Configuration capture: each FSM latches parity_mode and stop_bits at frame start. Changes mid-frame take effect on the next frame.
- TX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - Handshake: uart_tx_start && uart_tx_ready on a clock edge latches the data. uart_tx_ready is 0 from the next cycle.
  - Requests while ready=0 are ignored.
  - The start bit begins driving at the next tick.
  - Data is sent LSB first. PARITY is skipped when the captured mode is none.
  - STOP lasts 1 or 2 bit times, then the FSM returns to IDLE and ready=1 in the same cycle.
  - Even parity bit = XOR of the payload. Odd parity bit = its inverse.
- RX path:
  - uart_rx_d_in passes through a 2-flop synchroniser. Latency of 2 clocks is acceptable.
  - FSM states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: a high-to-low transition of the synchronised line arms START.
  - START: after OVERSAMPLE/2 ticks the line is sampled. Low means the start bit is valid and the phase counter resets. High means a glitch; return to IDLE with no output.
  - Every later bit is sampled after OVERSAMPLE ticks, i.e. at mid-bit. Bits are shifted in LSB first.
  - STOP: only the first stop bit is checked. On that sample: uart_rx_valid=1 for one clock, uart_received_data updated, parity_err = parity mismatch (0 when parity is none), frame_err = stop sample low. Then IDLE.
  - The second stop bit is never checked, so back-to-back frames are received.
  - Error flags hold until the next uart_rx_valid.
- TX and RX are independent. Both share the tick and operate simultaneously.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each RX sample, including the start-bit check, is the 2-of-3 majority of the synchronised line at mid-bit tick offsets -1, 0 and +1.
- Undefined: single sample at the mid-bit tick.
- Port list and timing of uart_rx_valid are identical in both builds.

Decomposition:
- Package uart_pkg:
  - parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - tx_state_t and rx_state_t enums.
  - Localparam MAX_DATA_BITS=9.
- One sub-module, uart_baud_tick: divisor counter and tick output, shared by TX and RX.

Test Plan:
- Common setup: CLOCK_FREQ=10000000, OVERSAMPLE=16, baud_div=3 (64 clocks per bit), TX looped back to RX.
- Loopback 0x02, no parity, 1 stop -> exactly one rx_valid, data 0x02, both error flags 0. uart_tx_ready low for 640 ±4 clocks.
- Loopback 0x0A, even parity, 2 stop -> TX parity bit 0, frame 12 bits long, rx data 0x0A, parity_err 0. Repeat with odd parity -> parity bit 1, parity_err 0.
- RX driven directly with 0x55, even parity and a forced wrong parity bit -> rx_valid with parity_err=1. Separate frame with the stop bit forced low -> frame_err=1.
- 20-clock low glitch on the idle RX line -> no rx_valid; the next valid frame 0xA5 is received correctly.
- uart_reset pulsed at TX bit 3 -> tx_d_out=1 and ready=1 on the next cycle, no rx_valid. A new request for 0x31 then completes normally.
- baud_div changed from 3 to 1 mid-TX -> the current frame finishes. Transmission of the next frame (sent at 32 clocks/bit) with RX configured to match gives data 0x0A.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and limits for uart_core_cfg.
package uart_pkg;
  localparam int MAX_DATA_BITS = 9;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_mode_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  function automatic logic par_on(input logic [1:0] m);
    return m == PAR_EVEN || m == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one tick every baud_div+1 clocks.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk_int,
  input  logic             uart_reset,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q >= baud_div;  // >= so a divisor lowered mid-count wraps at once
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_int)
    if (uart_reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_core_cfg.sv
// uart_core_cfg: configurable full-duplex UART with programmable divisor, parity and stop bits.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority RX sampling around mid-bit.
module uart_core_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 10000000,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk_int,
  input  logic                 uart_reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic [DATA_BITS-1:0] uart_transmit_data,
  input  logic                 uart_tx_start,
  output logic                 uart_tx_ready,
  output logic                 uart_tx_d_out,
  input  logic                 uart_rx_d_in,
  output logic [DATA_BITS-1:0] uart_received_data,
  output logic                 uart_rx_valid,
  output logic                 uart_rx_parity_err,
  output logic                 uart_rx_frame_err
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(MAX_DATA_BITS + 1);
  localparam logic [SW-1:0] SUB_END = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SUB_MID = SW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] BIT_END = BW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int HW = 2;
`else
  localparam int HW = 1;
`endif
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || CLOCK_FREQ <= 0) begin : g_bad_cfg
    $error("uart_core_cfg: illegal parameter set");
  end
  logic tick;
  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (.clk_int(clk_int), .uart_reset(uart_reset), .baud_div(baud_div), .tick(tick));
  tx_state_t tx_state_q, tx_state_d;
  logic [SW-1:0] tx_sub_q, tx_sub_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic tx_go_q, tx_go_d, tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_stop2_q, tx_stop2_d, tx_end;
  rx_state_t rx_state_q, rx_state_d;
  logic [SW-1:0] rx_sub_q, rx_sub_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [HW-1:0] rx_hist_q, rx_hist_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_hit, rx_smp;
  logic rx_par_bit_q, rx_par_bit_d, rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
  logic rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  always_ff @(posedge clk_int)
    if (uart_reset) begin
      tx_state_q <= TX_IDLE;
      tx_sub_q <= '0;
      tx_bit_q <= '0;
      tx_shift_q <= '0;
      tx_go_q <= 1'b0;
      tx_par_q <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_sub_q <= '0;
      rx_bit_q <= '0;
      rx_shift_q <= '0;
      rx_data_q <= '0;
      rx_hist_q <= '1;
      {rx_s1_q, rx_s2_q, rx_prev_q} <= 3'b111;
      {rx_par_bit_q, rx_par_en_q, rx_odd_q} <= 3'b000;
      {rx_valid_q, rx_perr_q, rx_ferr_q} <= 3'b000;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sub_q <= tx_sub_d;
      tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_go_q <= tx_go_d;
      tx_par_q <= tx_par_d;
      tx_par_en_q <= tx_par_en_d;
      tx_stop2_q <= tx_stop2_d;
      rx_state_q <= rx_state_d;
      rx_sub_q <= rx_sub_d;
      rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q <= rx_data_d;
      rx_hist_q <= rx_hist_d;
      {rx_s1_q, rx_s2_q, rx_prev_q} <= {uart_rx_d_in, rx_s1_q, rx_s2_q};
      {rx_par_bit_q, rx_par_en_q, rx_odd_q} <= {rx_par_bit_d, rx_par_en_d, rx_odd_d};
      {rx_valid_q, rx_perr_q, rx_ferr_q} <= {rx_valid_d, rx_perr_d, rx_ferr_d};
    end
  // tx_go marks the first tick after acceptance; bit timing starts there
  assign tx_end = tick && tx_go_q && tx_sub_q == SUB_END;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sub_d = (tick && tx_go_q) ? (tx_end ? '0 : tx_sub_q + 1'b1) : tx_sub_q;
    tx_bit_d = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_go_d = tx_go_q;
    tx_par_d = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d = tx_stop2_q;
    case (tx_state_q)
      TX_IDLE: if (uart_tx_start) begin
        tx_state_d = TX_START;
        tx_shift_d = uart_transmit_data;
        tx_par_d = ^uart_transmit_data ^ (parity_mode == PAR_ODD);
        tx_par_en_d = par_on(parity_mode);
        tx_stop2_d = stop_bits;
        tx_go_d = 1'b0;
        tx_sub_d = '0;
      end
      TX_START: if (tick && !tx_go_q) tx_go_d = 1'b1;
        else if (tx_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d = '0;
        end
      TX_DATA: if (tx_end) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d = tx_bit_q == BIT_END ? '0 : tx_bit_q + 1'b1;
        if (tx_bit_q == BIT_END) tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_end) begin
        tx_state_d = TX_STOP;
        tx_bit_d = '0;
      end
      TX_STOP: if (tx_end) begin
        if (tx_stop2_q && tx_bit_q == '0) tx_bit_d = BW'(1);
        else begin
          tx_state_d = TX_IDLE;
          tx_go_d = 1'b0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end
  always_comb begin
    uart_tx_ready = tx_state_q == TX_IDLE;
    uart_tx_d_out = tx_state_q == TX_START ? ~tx_go_q :
                    tx_state_q == TX_DATA ? tx_shift_q[0] :
                    tx_state_q == TX_PARITY ? tx_par_q : 1'b1;
  end
  // Decisions fall one tick after mid-bit so both sample modes share timing
`ifdef UART_RX_MAJORITY_EN
  assign rx_smp = (rx_hist_q[1] & rx_hist_q[0]) | (rx_hist_q[1] & rx_s2_q) | (rx_hist_q[0] & rx_s2_q);
`else
  assign rx_smp = rx_hist_q[0];
`endif
  assign rx_hit = tick && rx_sub_q == (rx_state_q == RX_START ? SUB_MID : SUB_END);
  always_comb begin
    rx_hist_d = tick ? HW'({rx_hist_q, rx_s2_q}) : rx_hist_q;
    rx_sub_d = rx_state_q == RX_IDLE ? '0 : rx_hit ? '0 : tick ? rx_sub_q + 1'b1 : rx_sub_q;
    rx_state_d = rx_state_q;
    rx_bit_d = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_bit_d = rx_par_bit_q;
    rx_par_en_d = rx_par_en_q;
    rx_odd_d = rx_odd_q;
    rx_valid_d = 1'b0;
    rx_data_d = rx_data_q;
    rx_perr_d = rx_perr_q;
    rx_ferr_d = rx_ferr_q;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = RX_START;
        rx_par_en_d = par_on(parity_mode);
        rx_odd_d = parity_mode == PAR_ODD;
      end
      RX_START: if (rx_hit) begin
        rx_state_d = rx_smp ? RX_IDLE : RX_DATA;
        rx_bit_d = '0;
      end
      RX_DATA: if (rx_hit) begin
        rx_shift_d = {rx_smp, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == BIT_END) rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_hit) begin
        rx_par_bit_d = rx_smp;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_hit) begin
        rx_valid_d = 1'b1;
        rx_data_d = rx_shift_q;
        rx_perr_d = rx_par_en_q & (rx_par_bit_q ^ (^rx_shift_q) ^ rx_odd_q);
        rx_ferr_d = ~rx_smp;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end
  assign uart_received_data = rx_data_q;
  assign uart_rx_valid = rx_valid_q;
  assign uart_rx_parity_err = rx_perr_q;
  assign uart_rx_frame_err = rx_ferr_q;
endmodule
